// File: rtl/vga_timing_pkg.sv
// Shared constants and the output bundle carried by the VGA timing delay line.
package vga_timing_pkg;

  localparam int unsigned VGA_H_ACTIVE = 640;
  localparam int unsigned VGA_H_FRONT  = 16;
  localparam int unsigned VGA_H_SYNC   = 96;
  localparam int unsigned VGA_H_BACK   = 48;
  localparam int unsigned VGA_V_ACTIVE = 480;
  localparam int unsigned VGA_V_FRONT  = 10;
  localparam int unsigned VGA_V_SYNC   = 2;
  localparam int unsigned VGA_V_BACK   = 33;

  // Coordinate fields are sized for the widest supported counter; narrower
  // instances zero-extend into them.
  localparam int unsigned COORD_MAX_W = 16;

  typedef struct packed {
    logic                   hsync;
    logic                   vsync;
    logic                   valid;
    logic [COORD_MAX_W-1:0] h_cnt;
    logic [COORD_MAX_W-1:0] v_cnt;
    logic [COORD_MAX_W-1:0] h_scl;
    logic [COORD_MAX_W-1:0] v_scl;
    logic                   sol;
    logic                   sof;
    logic                   eof;
  } vga_bundle_t;

  // Inactive bundle: syncs at their idle level, everything else zero.
  function automatic vga_bundle_t vga_idle_bundle(input logic hsync_pol, input logic vsync_pol);
    vga_bundle_t b;
    b       = '0;
    b.hsync = ~hsync_pol;
    b.vsync = ~vsync_pol;
    return b;
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Enable-gated shift register for the timing bundle; pass-through at depth 0.
module vga_delay_line
  import vga_timing_pkg::*;
#(
  parameter int unsigned DEPTH   = 0,
  parameter vga_bundle_t RST_VAL = '0
) (
  input  logic        pclk,
  input  logic        reset,
  input  logic        en,
  input  vga_bundle_t d,
  output vga_bundle_t q
);

  if (DEPTH == 0) begin : g_pass
    logic unused_ctl;
    assign unused_ctl = pclk ^ reset ^ en;
    assign q = d;
  end else begin : g_pipe
    vga_bundle_t stage [DEPTH];

    always_ff @(posedge pclk or negedge reset) begin
      if (!reset) begin
        for (int i = 0; i < int'(DEPTH); i++) stage[i] <= RST_VAL;
      end else if (en) begin
        stage[0] <= d;
        for (int i = 1; i < int'(DEPTH); i++) stage[i] <= stage[i-1];
      end
    end

    assign q = stage[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with pixel enable, sync polarity,
// latency-matched output bundle, scaled coordinates, strobes and frame count.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE    = VGA_H_ACTIVE,
  parameter int unsigned H_FRONT     = VGA_H_FRONT,
  parameter int unsigned H_SYNC      = VGA_H_SYNC,
  parameter int unsigned H_BACK      = VGA_H_BACK,
  parameter int unsigned V_ACTIVE    = VGA_V_ACTIVE,
  parameter int unsigned V_FRONT     = VGA_V_FRONT,
  parameter int unsigned V_SYNC      = VGA_V_SYNC,
  parameter int unsigned V_BACK      = VGA_V_BACK,
  parameter logic        HSYNC_POL   = 1'b0,
  parameter logic        VSYNC_POL   = 1'b0,
  parameter int unsigned PIPE        = 0,
  parameter int unsigned SCALE_SHIFT = 1,
  parameter int unsigned CNT_W       = 10,
  parameter int unsigned FRAME_W     = 8
) (
  input  logic               pclk,
  input  logic               reset,
  input  logic               pix_en,
  output logic               hsync,
  output logic               vsync,
  output logic               valid,
  output logic [CNT_W-1:0]   h_cnt,
  output logic [CNT_W-1:0]   v_cnt,
  output logic [CNT_W-1:0]   h_scl,
  output logic [CNT_W-1:0]   v_scl,
  output logic               sol,
  output logic               sof,
  output logic               eof,
  output logic [FRAME_W-1:0] frame_cnt
);

  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned HS_START = H_ACTIVE + H_FRONT;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FRONT;
  localparam int unsigned VS_END   = VS_START + V_SYNC;

  if (64'(H_TOTAL) > (64'(1) << CNT_W)) begin : g_bad_htotal
    $error("vga_timing_gen: H_TOTAL does not fit in CNT_W bits");
  end
  if (64'(V_TOTAL) > (64'(1) << CNT_W)) begin : g_bad_vtotal
    $error("vga_timing_gen: V_TOTAL does not fit in CNT_W bits");
  end
  if (PIPE > 4) begin : g_bad_pipe
    $error("vga_timing_gen: PIPE must be 0..4");
  end
  if (CNT_W > COORD_MAX_W) begin : g_bad_cntw
    $error("vga_timing_gen: CNT_W exceeds bundle coordinate width");
  end

  logic [CNT_W-1:0]   pix_q;
  logic [CNT_W-1:0]   line_q;
  logic [FRAME_W-1:0] frame_q;
  logic               line_end_c;
  logic               frame_end_c;
  logic [31:0]        pix32_c;
  logic [31:0]        line32_c;
  logic               in_h_act_c;
  logic               in_v_act_c;
  vga_bundle_t        raw_c;
  vga_bundle_t        dly_q;

  assign line_end_c  = (pix_q == CNT_W'(H_TOTAL - 1));
  assign frame_end_c = line_end_c && (line_q == CNT_W'(V_TOTAL - 1));

  // Raster position and completed-frame counters
  always_ff @(posedge pclk or negedge reset) begin
    if (!reset) begin
      pix_q   <= '0;
      line_q  <= '0;
      frame_q <= '0;
    end else if (pix_en) begin
      if (line_end_c) begin
        pix_q  <= '0;
        line_q <= frame_end_c ? '0 : line_q + CNT_W'(1);
      end else begin
        pix_q <= pix_q + CNT_W'(1);
      end
      if (frame_end_c) frame_q <= frame_q + FRAME_W'(1);
    end
  end

  assign pix32_c    = 32'(pix_q);
  assign line32_c   = 32'(line_q);
  assign in_h_act_c = (pix32_c < H_ACTIVE);
  assign in_v_act_c = (line32_c < V_ACTIVE);

  // Undelayed timing terms decoded from the counters
  always_comb begin
    raw_c       = '0;
    raw_c.valid = in_h_act_c && in_v_act_c;
    raw_c.hsync = (pix32_c >= HS_START && pix32_c < HS_END) ? HSYNC_POL : ~HSYNC_POL;
    raw_c.vsync = (line32_c >= VS_START && line32_c < VS_END) ? VSYNC_POL : ~VSYNC_POL;
    raw_c.h_cnt = raw_c.valid ? COORD_MAX_W'(pix_q) : '0;
    raw_c.v_cnt = raw_c.valid ? COORD_MAX_W'(line_q) : '0;
    raw_c.h_scl = raw_c.h_cnt >> SCALE_SHIFT;
    raw_c.v_scl = raw_c.v_cnt >> SCALE_SHIFT;
    raw_c.sol   = (pix_q == '0) && in_v_act_c;
    raw_c.sof   = (pix_q == '0) && (line_q == '0);
    raw_c.eof   = frame_end_c;
  end

  vga_delay_line #(
    .DEPTH   (PIPE),
    .RST_VAL (vga_idle_bundle(HSYNC_POL, VSYNC_POL))
  ) u_delay (
    .pclk  (pclk),
    .reset (reset),
    .en    (pix_en),
    .d     (raw_c),
    .q     (dly_q)
  );

  // Coordinate fields wider than CNT_W are always zero
  logic unused_bundle;
  assign unused_bundle = ^dly_q;

  assign hsync     = dly_q.hsync;
  assign vsync     = dly_q.vsync;
  assign valid     = dly_q.valid;
  assign h_cnt     = dly_q.h_cnt[CNT_W-1:0];
  assign v_cnt     = dly_q.v_cnt[CNT_W-1:0];
  assign h_scl     = dly_q.h_scl[CNT_W-1:0];
  assign v_scl     = dly_q.v_scl[CNT_W-1:0];
  assign sol       = dly_q.sol;
  assign sof       = dly_q.sof;
  assign eof       = dly_q.eof;
  assign frame_cnt = frame_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default PIPE=0, default PIPE=2 and a small-raster
// instance, all checked every cycle against a tick-based raster model.
module tb_vga_timing_gen;

  typedef struct {
    int ha, hf, hs, hb, va, vf, vs, vb;
    bit hp, vp;
    int sh, pipe, fw;
  } geom_t;

  typedef struct {
    bit hsync, vsync, valid;
    int hc, vc, hsc, vsc;
    bit sol, sof, eof;
    int fc;
  } exp_t;

  geom_t g_def  = '{ha:640, hf:16, hs:96, hb:48, va:480, vf:10, vs:2, vb:33,
                    hp:1'b0, vp:1'b0, sh:1, pipe:0, fw:8};
  geom_t g_def2 = '{ha:640, hf:16, hs:96, hb:48, va:480, vf:10, vs:2, vb:33,
                    hp:1'b0, vp:1'b0, sh:1, pipe:2, fw:8};
  geom_t g_sm   = '{ha:8, hf:2, hs:3, hb:3, va:4, vf:1, vs:2, vb:2,
                    hp:1'b0, vp:1'b1, sh:2, pipe:1, fw:2};

  logic pclk = 1'b0;
  logic reset = 1'b0;
  logic pix_en = 1'b0;
  int   en_mode = 0;
  int   div = 0;
  int   t = 0;
  int   errors = 0;
  int   checks = 0;

  logic       a_hs, a_vs, a_va, a_sol, a_sof, a_eof;
  logic [9:0] a_hc, a_vc, a_hsc, a_vsc;
  logic [7:0] a_fc;
  logic       b_hs, b_vs, b_va, b_sol, b_sof, b_eof;
  logic [9:0] b_hc, b_vc, b_hsc, b_vsc;
  logic [7:0] b_fc;
  logic       c_hs, c_vs, c_va, c_sol, c_sof, c_eof;
  logic [4:0] c_hc, c_vc, c_hsc, c_vsc;
  logic [1:0] c_fc;

  vga_timing_gen #(.PIPE(0)) dut0 (
    .pclk(pclk), .reset(reset), .pix_en(pix_en),
    .hsync(a_hs), .vsync(a_vs), .valid(a_va), .h_cnt(a_hc), .v_cnt(a_vc),
    .h_scl(a_hsc), .v_scl(a_vsc), .sol(a_sol), .sof(a_sof), .eof(a_eof),
    .frame_cnt(a_fc));

  vga_timing_gen #(.PIPE(2)) dut2 (
    .pclk(pclk), .reset(reset), .pix_en(pix_en),
    .hsync(b_hs), .vsync(b_vs), .valid(b_va), .h_cnt(b_hc), .v_cnt(b_vc),
    .h_scl(b_hsc), .v_scl(b_vsc), .sol(b_sol), .sof(b_sof), .eof(b_eof),
    .frame_cnt(b_fc));

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(2),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b1), .PIPE(1), .SCALE_SHIFT(2),
    .CNT_W(5), .FRAME_W(2)
  ) dsm (
    .pclk(pclk), .reset(reset), .pix_en(pix_en),
    .hsync(c_hs), .vsync(c_vs), .valid(c_va), .h_cnt(c_hc), .v_cnt(c_vc),
    .h_scl(c_hsc), .v_scl(c_vsc), .sol(c_sol), .sof(c_sof), .eof(c_eof),
    .frame_cnt(c_fc));

  always #5 pclk = ~pclk;

  // pix_en pattern: 0 off, 1 every clock, 2 one clock in four
  always @(posedge pclk) begin
    #1;
    case (en_mode)
      1: pix_en = 1'b1;
      2: begin pix_en = (div == 0); div = (div + 1) % 4; end
      default: pix_en = 1'b0;
    endcase
  end

  // Number of pixel ticks taken since the last reset
  always @(posedge pclk or negedge reset) begin
    if (!reset) t <= 0;
    else if (pix_en) t <= t + 1;
  end

  // Outputs after t ticks: raster position PIPE ticks back, frames from t
  function automatic exp_t model(geom_t g, int tk);
    exp_t e;
    int ht, vt, te, p, l;
    ht = g.ha + g.hf + g.hs + g.hb;
    vt = g.va + g.vf + g.vs + g.vb;
    e.fc = (tk / (ht * vt)) % (1 << g.fw);
    e.hsync = !g.hp; e.vsync = !g.vp; e.valid = 0;
    e.hc = 0; e.vc = 0; e.hsc = 0; e.vsc = 0;
    e.sol = 0; e.sof = 0; e.eof = 0;
    if (tk < g.pipe) return e;
    te = tk - g.pipe;
    p = te % ht;
    l = (te / ht) % vt;
    e.valid = (p < g.ha) && (l < g.va);
    e.hsync = (p >= g.ha + g.hf && p < g.ha + g.hf + g.hs) ? g.hp : !g.hp;
    e.vsync = (l >= g.va + g.vf && l < g.va + g.vf + g.vs) ? g.vp : !g.vp;
    e.hc = e.valid ? p : 0;
    e.vc = e.valid ? l : 0;
    e.hsc = e.hc >> g.sh;
    e.vsc = e.vc >> g.sh;
    e.sol = (p == 0) && (l < g.va);
    e.sof = (p == 0) && (l == 0);
    e.eof = (p == ht - 1) && (l == vt - 1);
    return e;
  endfunction

  task automatic cmp(string nm, exp_t e, bit hs, bit vs, bit va, int hc, int vc,
                     int hsc, int vsc, bit so, bit sf, bit ef, int fc);
    checks++;
    if (hs != e.hsync || vs != e.vsync || va != e.valid || hc != e.hc || vc != e.vc ||
        hsc != e.hsc || vsc != e.vsc || so != e.sol || sf != e.sof || ef != e.eof ||
        fc != e.fc) begin
      errors++;
      $display("FAIL %s t=%0d got hs=%0b vs=%0b va=%0b h=%0d v=%0d hs=%0d vs=%0d sol=%0b sof=%0b eof=%0b fc=%0d want hs=%0b vs=%0b va=%0b h=%0d v=%0d hs=%0d vs=%0d sol=%0b sof=%0b eof=%0b fc=%0d",
               nm, t, hs, vs, va, hc, vc, hsc, vsc, so, sf, ef, fc,
               e.hsync, e.vsync, e.valid, e.hc, e.vc, e.hsc, e.vsc, e.sol, e.sof, e.eof, e.fc);
    end
  endtask

  // Per-cycle comparison of all three instances against the model
  always @(negedge pclk) begin
    cmp("model_pipe0", model(g_def, t), a_hs, a_vs, a_va, int'(a_hc), int'(a_vc),
        int'(a_hsc), int'(a_vsc), a_sol, a_sof, a_eof, int'(a_fc));
    cmp("model_pipe2", model(g_def2, t), b_hs, b_vs, b_va, int'(b_hc), int'(b_vc),
        int'(b_hsc), int'(b_vsc), b_sol, b_sof, b_eof, int'(b_fc));
    cmp("model_small", model(g_sm, t), c_hs, c_vs, c_va, int'(c_hc), int'(c_vc),
        int'(c_hsc), int'(c_vsc), c_sol, c_sof, c_eof, int'(c_fc));
  end

  task automatic chk(string nm, int act, int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s t=%0d got %0d want %0d", nm, t, act, want);
    end
  endtask

  task automatic wait_tick(int n);
    int k;
    k = 0;
    while (t < n && k < 20000) begin
      @(negedge pclk);
      k++;
    end
    chk("wait_tick_reached", t, n);
  endtask

  int rises, cyc, rise0, rise1, hi_len, k;
  logic prev_sol;

  initial begin
    repeat (3) @(negedge pclk);
    #1;
    // Held in reset: PIPE=0 shows pixel 0 / line 0, delayed outputs idle
    chk("rst_h_cnt", int'(a_hc), 0);
    chk("rst_v_cnt", int'(a_vc), 0);
    chk("rst_valid", int'(a_va), 1);
    chk("rst_sof", int'(a_sof), 1);
    chk("rst_sol", int'(a_sol), 1);
    chk("rst_hsync", int'(a_hs), 1);
    chk("rst_vsync", int'(a_vs), 1);
    chk("rst_frame", int'(a_fc), 0);
    chk("rst_p2_valid", int'(b_va), 0);
    chk("rst_p2_hsync", int'(b_hs), 1);
    chk("rst_sm_vsync", int'(c_vs), 0);

    reset = 1'b1;
    en_mode = 1;

    wait_tick(80);  chk("sm_vsync_80", int'(c_vs), 0);
    wait_tick(81);  chk("sm_vsync_81", int'(c_vs), 1);
    wait_tick(112); chk("sm_vsync_112", int'(c_vs), 1);
    wait_tick(113); chk("sm_vsync_113", int'(c_vs), 0);
    wait_tick(144); chk("sm_frame_144", int'(c_fc), 1); chk("sm_sof_144", int'(c_sof), 0);
    wait_tick(145); chk("sm_sof_145", int'(c_sof), 1);
    wait_tick(575); chk("sm_frame_575", int'(c_fc), 3);
    wait_tick(576); chk("sm_frame_wrap", int'(c_fc), 0);
    wait_tick(639); chk("p0_h_639", int'(a_hc), 639); chk("p0_valid_639", int'(a_va), 1);
    chk("p0_hscl_639", int'(a_hsc), 319);
    wait_tick(640); chk("p0_valid_640", int'(a_va), 0); chk("p0_h_640", int'(a_hc), 0);
    wait_tick(641); chk("p2_h_641", int'(b_hc), 639); chk("p2_hscl_641", int'(b_hsc), 319);
    wait_tick(642); chk("p2_valid_642", int'(b_va), 0); chk("p2_h_642", int'(b_hc), 0);
    wait_tick(655); chk("hsync_655", int'(a_hs), 1);
    wait_tick(656); chk("hsync_656", int'(a_hs), 0);
    wait_tick(751); chk("hsync_751", int'(a_hs), 0);
    wait_tick(752); chk("hsync_752", int'(a_hs), 1);
    wait_tick(800); chk("sol_800", int'(a_sol), 1); chk("v_800", int'(a_vc), 1);
    chk("h_800", int'(a_hc), 0);
    wait_tick(1900); chk("mid_h", int'(a_hc), 300); chk("mid_v", int'(a_vc), 2);

    // Asynchronous reset between clock edges
    #2 reset = 1'b0;
    #1;
    chk("arst_p2_valid", int'(b_va), 0);
    chk("arst_p2_hsync", int'(b_hs), 1);
    chk("arst_p2_h", int'(b_hc), 0);
    chk("arst_p0_sof", int'(a_sof), 1);
    chk("arst_p0_h", int'(a_hc), 0);
    repeat (2) @(negedge pclk);
    reset = 1'b1;
    wait_tick(1); chk("rel_p2_sof_1", int'(b_sof), 0);
    wait_tick(2); chk("rel_p2_sof_2", int'(b_sof), 1); chk("rel_p0_h_2", int'(a_hc), 2);

    // One pixel tick every four clocks: measure line period and strobe width
    en_mode = 2;
    rises = 0; cyc = 0; rise0 = 0; rise1 = 0; hi_len = 0; k = 0;
    prev_sol = a_sol;
    while (rises < 2 && k < 20000) begin
      @(negedge pclk);
      k++;
      cyc++;
      if (a_sol && !prev_sol) begin
        if (rises == 0) rise0 = cyc; else rise1 = cyc;
        rises++;
      end
      if (rises == 1 && a_sol) hi_len++;
      prev_sol = a_sol;
    end
    chk("div4_rises", rises, 2);
    chk("div4_line_period", rise1 - rise0, 3200);
    chk("div4_sol_width", hi_len, 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
